param_rr_arbitor: RTL and testbench
===================================

PARAM_RR_ARBITOR -- requirements
Module: param_rr_arbitor

Interface
REQ-001 SHALL have parameter SLAVE_COUNT, default 4: number of requesters; legal range 2..32, non-power-of-two values included.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 0: maximum grant hold in cycles; 0 disables the timeout.
REQ-003 SHALL define localparam IDW = max(1, $clog2(SLAVE_COUNT)).
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 SHALL have port clock, input, 1 bit: rising-edge clock for all state.
REQ-006 SHALL have port aresetn, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port request, input, SLAVE_COUNT bits: per-requester request level.
REQ-008 SHALL have port done, input, SLAVE_COUNT bits: per-requester release pulse.
REQ-009 SHALL have port grant, output, SLAVE_COUNT bits: registered one-hot grant.
REQ-010 SHALL have port grant_valid, output, 1 bit: high when grant is non-zero.
REQ-011 SHALL have port grant_id, output, IDW bits: index of the granted requester; 0 when not valid.
REQ-012 SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-013 SHALL use two states: IDLE and BUSY.
REQ-014 In IDLE with request != 0, SHALL select the first set request bit searching from ptr upward, modulo SLAVE_COUNT.
REQ-015 SHALL register that selection, entering BUSY with the grant visible the cycle after the request is seen (latency 1).
REQ-016 In IDLE with request == 0, SHALL stay in IDLE with grant = 0.
REQ-017 SHALL keep grant one-hot or zero at all times, and keep it constant while in BUSY.
REQ-018 In BUSY, done[grant_id] = 1 SHALL release: next cycle state = IDLE, grant = 0.
REQ-019 In BUSY, request[grant_id] = 0 without done SHALL also release (abort), with the same timing as done.
REQ-020 done bits of non-granted requesters SHALL be ignored.
REQ-021 On every release, ptr SHALL load (grant_id + 1) mod SLAVE_COUNT; wrap-around from SLAVE_COUNT-1 gives 0.
REQ-022 After a release, at least one grant-free cycle SHALL occur; the earliest new grant is 2 cycles after done.
REQ-023 When TIMEOUT_CYCLES > 0, the hold counter SHALL reset to 0 on entry to BUSY and increment each BUSY cycle.
REQ-024 When the hold counter reaches TIMEOUT_CYCLES-1 without a release, SHALL force a release: timeout = 1 for one cycle, coincident with grant dropping to 0; ptr advances per REQ-021.
REQ-025 done and timeout in the same cycle SHALL be treated as a normal release with timeout = 0.
REQ-026 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1 bit; the counter SHALL never wrap.
REQ-027 ptr SHALL NOT change except on release, so a requester that is skipped is reached within SLAVE_COUNT grants (starvation-free).

Reset
REQ-028 On aresetn = 0 at a rising clock edge, SHALL set state = IDLE, ptr = 0, grant = 0, grant_valid = 0, grant_id = 0, timeout = 0, counter = 0.
REQ-029 Reset SHALL override any in-progress grant immediately; no release pulse and no ptr advance SHALL occur.
REQ-030 Outputs SHALL be purely registered, with no combinational path from request or done to outputs.

Verification (SLAVE_COUNT = 4, TIMEOUT_CYCLES = 8 unless noted)
REQ-031 After reset, request = 4'b1111 held, each grant released by done after 2 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001, with one zero cycle between grants.
REQ-032 ptr = 2, request = 4'b0011 -> grant = 0001 one cycle later; after done, ptr = 1 and the next grant is 0010.
REQ-033 Grant held to requester 1 with no done -> after 8 BUSY cycles, grant = 0, timeout = 1 for one cycle, and the next grant goes to requester 2 if it is requesting.
REQ-034 While granted to requester 3, drop request[3] and pulse done[0] -> release on the abort only; done[0] has no effect; ptr = 0.
REQ-035 aresetn = 0 asserted mid-BUSY -> the next cycle has all outputs 0 and ptr = 0; with request = 4'b1000 after reset, grant = 1000 next cycle.
REQ-036 SLAVE_COUNT = 3, TIMEOUT_CYCLES = 0, request = 3'b111 -> grant cycles 001, 010, 100, 001; no timeout ever asserts.

Source files
------------

// File: rtl/param_rr_arbitor.sv
// Round-robin arbiter: grants one requester at a time, searching upward from a
// rotating pointer, with optional forced release after TIMEOUT_CYCLES of hold.
module param_rr_arbitor #(
    parameter int  SLAVE_COUNT    = 4,
    parameter int  TIMEOUT_CYCLES = 0,
    localparam int IDW            = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1
) (
    input  logic                   clock,
    input  logic                   aresetn,
    input  logic [SLAVE_COUNT-1:0] request,
    input  logic [SLAVE_COUNT-1:0] done,
    output logic [SLAVE_COUNT-1:0] grant,
    output logic                   grant_valid,
    output logic [IDW-1:0]         grant_id,
    output logic                   timeout,
    output logic                   fsm_state
);

    localparam int  CNTW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int  CNTW     = (CNTW_RAW < 1) ? 1 : CNTW_RAW;
    localparam int  LAST_I   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit  TMO_EN   = (TIMEOUT_CYCLES > 0);

    localparam logic [CNTW-1:0]        HOLD_LAST = CNTW'(LAST_I);
    localparam logic [IDW-1:0]         LAST_ID   = IDW'(SLAVE_COUNT - 1);
    localparam logic [IDW:0]           COUNT_W   = (IDW + 1)'(SLAVE_COUNT);
    localparam logic [SLAVE_COUNT-1:0] ONE_HOT0  = SLAVE_COUNT'(1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                     state;
    logic [IDW-1:0]             ptr;
    logic [CNTW-1:0]            hold_cnt;

    logic [2*SLAVE_COUNT-1:0]   req2;
    logic [SLAVE_COUNT-1:0]     rot;
    logic                       sel_found;
    logic [IDW-1:0]             sel_id;
    logic [IDW:0]               sum;
    logic                       normal_rel;
    logic                       forced_rel;

    // Debug view of the FSM: 1 while a grant is being held.
    assign fsm_state = (state == BUSY);

    // Rotate requests so bit 0 is the requester at ptr, then take the lowest set bit.
    assign req2 = {request, request};
    assign rot  = SLAVE_COUNT'(req2 >> ptr);

    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        sum       = '0;
        for (int i = 0; i < SLAVE_COUNT; i++) begin
            if (!sel_found && rot[i]) begin
                sel_found = 1'b1;
                sum       = {1'b0, ptr} + (IDW + 1)'(i);
                if (sum >= COUNT_W) begin
                    sum = sum - COUNT_W;
                end
                sel_id = sum[IDW-1:0];
            end
        end
    end

    // grant is one-hot while BUSY, so masking picks out the holder's own bits.
    assign normal_rel = (|(done & grant)) || !(|(request & grant));
    assign forced_rel = TMO_EN && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clock) begin
        if (!aresetn) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            timeout     <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        state       <= BUSY;
                        grant       <= ONE_HOT0 << sel_id;
                        grant_valid <= 1'b1;
                        grant_id    <= sel_id;
                        hold_cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (normal_rel || forced_rel) begin
                        state       <= IDLE;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_id    <= '0;
                        hold_cnt    <= '0;
                        timeout     <= !normal_rel;
                        ptr         <= (grant_id == LAST_ID) ? '0 : grant_id + IDW'(1);
                    end else if (TMO_EN) begin
                        hold_cnt <= hold_cnt + CNTW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_rr_arbitor.sv
// Bench for param_rr_arbitor: a 4-way/timeout-8 instance and a 3-way/no-timeout
// instance, directed scenarios followed by random traffic against a reference model.
module tb_param_rr_arbitor;

    // ---------------- clock / reset ----------------
    logic clock;
    logic aresetn;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- DUT A: 4 requesters, timeout 8 ----------------
    logic [3:0] req_a, done_a, grant_a;
    logic       valid_a, tmo_a, st_a;
    logic [1:0] id_a;

    param_rr_arbitor #(.SLAVE_COUNT(4), .TIMEOUT_CYCLES(8)) dut_a (
        .clock(clock), .aresetn(aresetn), .request(req_a), .done(done_a),
        .grant(grant_a), .grant_valid(valid_a), .grant_id(id_a),
        .timeout(tmo_a), .fsm_state(st_a)
    );

    // ---------------- DUT B: 3 requesters, no timeout ----------------
    logic [2:0] req_b, done_b, grant_b;
    logic       valid_b, tmo_b, st_b;
    logic [1:0] id_b;

    param_rr_arbitor #(.SLAVE_COUNT(3), .TIMEOUT_CYCLES(0)) dut_b (
        .clock(clock), .aresetn(aresetn), .request(req_b), .done(done_b),
        .grant(grant_b), .grant_valid(valid_b), .grant_id(id_b),
        .timeout(tmo_b), .fsm_state(st_b)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit busy;
        int ptr;
        int gid;
        int held;
        bit tmo;
    } mstate_t;

    mstate_t ma, mb;
    bit      started;

    // One clock edge of the arbiter, from the rules: who holds the grant, for how long.
    function automatic mstate_t step(mstate_t s, int n, int t,
                                     logic [31:0] req, logic [31:0] dn, bit rst);
        mstate_t r;
        bit      found;
        bit      released;
        bit      forced;
        r     = s;
        r.tmo = 1'b0;
        if (rst) begin
            r = '{busy: 1'b0, ptr: 0, gid: 0, held: 0, tmo: 1'b0};
            return r;
        end
        if (!s.busy) begin
            found = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (!found && req[(s.ptr + k) % n]) begin
                    found  = 1'b1;
                    r.busy = 1'b1;
                    r.gid  = (s.ptr + k) % n;
                    r.held = 0;
                end
            end
        end else begin
            released = dn[s.gid] || !req[s.gid];
            forced   = (t > 0) && (s.held + 1 == t);
            if (released || forced) begin
                r.busy = 1'b0;
                r.ptr  = (s.gid + 1) % n;
                r.gid  = 0;
                r.held = 0;
                r.tmo  = forced && !released;
            end else begin
                r.held = s.held + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] m_grant(mstate_t s);
        return s.busy ? (32'd1 << s.gid) : 32'd0;
    endfunction

    initial begin
        ma      = '{busy: 1'b0, ptr: 0, gid: 0, held: 0, tmo: 1'b0};
        mb      = '{busy: 1'b0, ptr: 0, gid: 0, held: 0, tmo: 1'b0};
        started = 1'b0;
    end

    always @(posedge clock) begin
        ma      <= step(ma, 4, 8, 32'(req_a), 32'(done_a), !aresetn);
        mb      <= step(mb, 3, 0, 32'(req_b), 32'(done_b), !aresetn);
        started <= 1'b1;
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (started) begin
            check("a_grant", 32'(grant_a), m_grant(ma));
            check("a_valid", 32'(valid_a), 32'(ma.busy));
            check("a_id",    32'(id_a),    32'(ma.busy ? ma.gid : 0));
            check("a_tmo",   32'(tmo_a),   32'(ma.tmo));
            check("a_state", 32'(st_a),    32'(ma.busy));
            check("b_grant", 32'(grant_b), m_grant(mb));
            check("b_valid", 32'(valid_b), 32'(mb.busy));
            check("b_id",    32'(id_b),    32'(mb.busy ? mb.gid : 0));
            check("b_tmo",   32'(tmo_b),   32'(mb.tmo));
            check("b_state", 32'(st_b),    32'(mb.busy));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic expect_a(input string name, input logic [3:0] g, input logic t);
        check(name, 32'(grant_a), 32'(g));
        check({name, "_tmo"}, 32'(tmo_a), 32'(t));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] ea;
        logic [2:0] eb;

        aresetn = 1'b0;
        req_a   = '0;
        done_a  = '0;
        req_b   = '0;
        done_b  = '0;
        tick();
        tick();
        expect_a("rst_grant", 4'b0000, 1'b0);
        check("rst_id", 32'(id_a), 32'd0);
        check("rst_b_grant", 32'(grant_b), 32'd0);
        aresetn = 1'b1;

        // 3-way rotation, no timeout instance
        req_b = 3'b111;
        for (int k = 0; k < 4; k++) begin
            eb = 3'(1 << (k % 3));
            tick();
            check("b_rr_grant", 32'(grant_b), 32'(eb));
            done_b = eb;
            tick();
            done_b = '0;
            check("b_rr_gap", 32'(grant_b), 32'd0);
            if (k == 3) req_b = '0;
        end

        // full request, done after two cycles of grant
        req_a = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            ea = 4'(1 << (k % 4));
            tick();
            expect_a("rr_grant_c1", ea, 1'b0);
            tick();
            expect_a("rr_grant_c2", ea, 1'b0);
            done_a = ea;
            tick();
            done_a = '0;
            expect_a("rr_gap", 4'b0000, 1'b0);
            if (k == 4) req_a = '0;
        end

        // bring ptr to 2, then request 0011 picks 0 first, then 1
        req_a = 4'b0010;
        tick();
        expect_a("set_ptr_g1", 4'b0010, 1'b0);
        done_a = 4'b0010;
        req_a  = '0;
        tick();
        done_a = '0;
        expect_a("set_ptr_rel", 4'b0000, 1'b0);
        req_a = 4'b0011;
        tick();
        expect_a("ptr2_pick0", 4'b0001, 1'b0);
        done_a = 4'b0001;
        tick();
        done_a = '0;
        expect_a("ptr2_rel", 4'b0000, 1'b0);
        tick();
        expect_a("ptr1_pick1", 4'b0010, 1'b0);
        req_a = '0;
        tick();
        expect_a("abort1", 4'b0000, 1'b0);

        // timeout: requester 1 holds 8 cycles, then 2 is served
        req_a = 4'b0010;
        tick();
        expect_a("tmo_hold", 4'b0010, 1'b0);
        req_a = 4'b0110;
        for (int h = 1; h < 8; h++) begin
            tick();
            expect_a("tmo_hold", 4'b0010, 1'b0);
        end
        tick();
        expect_a("tmo_fire", 4'b0000, 1'b1);
        tick();
        expect_a("tmo_next2", 4'b0100, 1'b0);
        req_a = '0;
        tick();
        expect_a("tmo_next2_abort", 4'b0000, 1'b0);

        // foreign done ignored; abort of requester 3 wraps ptr to 0
        req_a = 4'b1001;
        tick();
        expect_a("gnt3", 4'b1000, 1'b0);
        done_a = 4'b0001;
        tick();
        expect_a("done0_ignored", 4'b1000, 1'b0);
        req_a  = 4'b0001;
        done_a = 4'b0001;
        tick();
        expect_a("abort3", 4'b0000, 1'b0);
        done_a = '0;
        req_a  = 4'b0011;
        tick();
        expect_a("ptr0_after_abort", 4'b0001, 1'b0);
        req_a = '0;
        tick();
        expect_a("abort0", 4'b0000, 1'b0);

        // reset in the middle of a grant
        req_a = 4'b0100;
        tick();
        expect_a("pre_rst_busy", 4'b0100, 1'b0);
        aresetn = 1'b0;
        tick();
        expect_a("rst_mid_busy", 4'b0000, 1'b0);
        check("rst_mid_valid", 32'(valid_a), 32'd0);
        check("rst_mid_id", 32'(id_a), 32'd0);
        aresetn = 1'b1;
        req_a   = 4'b1000;
        tick();
        expect_a("post_rst_3", 4'b1000, 1'b0);
        req_a = '0;
        tick();
        expect_a("post_rst_abort", 4'b0000, 1'b0);

        // random traffic, checked every cycle against the model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 7) == 0) req_a[i] = ~req_a[i];
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 7) == 0) req_b[i] = ~req_b[i];
            done_a = '0;
            done_b = '0;
            if ($urandom_range(0, 5) == 0) done_a = grant_a;
            if ($urandom_range(0, 3) == 0) done_a[$urandom_range(0, 3)] = 1'b1;
            if ($urandom_range(0, 4) == 0) done_b = grant_b;
            if ($urandom_range(0, 3) == 0) done_b[$urandom_range(0, 2)] = 1'b1;
            aresetn = ($urandom_range(0, 399) != 0);
        end

        req_a   = '0;
        done_a  = '0;
        req_b   = '0;
        done_b  = '0;
        aresetn = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
